rsff_stim_chk: RTL and testbench



---
 rtl/rsff_tb_pkg.sv | 29 ++
 rtl/rsff_stim_chk_lfsr16.sv | 24 ++
 rtl/rsff_stim_chk.sv | 125 ++++++++++++
 tb/tb_rsff_stim_chk.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rsff_tb_pkg.sv
// rsff_tb_pkg: shared encodings and LFSR helper for the techmap sequential stimulus/checker benches
// Provides: state_t (IDLE/INIT/RUN/DRAIN/DONE), pulse_kind_t, LFSR_TAPS, DEFAULT_SEED, lfsr_step()
package rsff_tb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // lfsr[5:4] on a pulse cycle; 2'b11 is a second reset code
    typedef enum logic [1:0] {
        PK_RST     = 2'b00,
        PK_SET     = 2'b01,
        PK_BOTH    = 2'b10,
        PK_RST_ALT = 2'b11
    } pulse_kind_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci, shifting left: taps on bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rsff_stim_chk_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR with seed reload, shared by the techmap sequential benches
// Ports: clk, reset (async, active-high), load (reseed), en (advance), value (current state)
module lfsr16 import rsff_tb_pkg::*; #(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    output logic [15:0] value
);

    // the all-zero state would lock up, so it is replaced by 1
    localparam logic [15:0] START = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            value <= START;
        else if (load)
            value <= START;
        else if (en)
            value <= lfsr_step(value);

endmodule

// File: rtl/rsff_stim_chk.sv
// rsff_stim_chk: LFSR-driven stimulus generator and golden-model checker for the RSFF techmap cell
// Ports: clk, reset (async, active-high), start (run request in IDLE/DONE)
//        dut_d / dut_reset (active-high) / dut_set (active-low) drive the cell, dut_q is its output
//        busy (INIT/RUN/DRAIN), done, pass, err_count (saturating), first_err_vec (16'hFFFF = none)
module rsff_stim_chk import rsff_tb_pkg::*; #(
    parameter logic [15:0] SEED       = DEFAULT_SEED,
    parameter int unsigned NUM_VEC    = 256,
    parameter logic [3:0]  PULSE_MASK = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dut_d,
    output logic        dut_reset,
    output logic        dut_set,
    input  logic        dut_q,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_vec
);

    // the vector counter only widens when a run is longer than 16 bits can index
    localparam int CW = (NUM_VEC > 65535) ? 32 : 16;
    localparam logic [CW-1:0] LAST = CW'(NUM_VEC - 1);

    state_t       state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]  lfsr;
    logic         lfsr_load, load_vec;
    logic         prev_pulse, prev_pulse_n, pulse;
    pulse_kind_t  kind;
    logic         model_q, exp_q, miss, clr;
    logic         d_n, r_n, s_n;
    logic [15:0]  err_n, fev_n;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (lfsr_load),
        .en    (load_vec),
        .value (lfsr)
    );

    always_comb begin
        // a pulse is never allowed back to back, so async levels never straddle an edge
        pulse = ((lfsr & {12'h000, PULSE_MASK}) == 16'h0000) && !prev_pulse;
        kind  = pulse_kind_t'(lfsr[5:4]);
        // model_q is what the cell latched at the last edge; async pins override it, reset first
        exp_q = dut_reset ? 1'b0 : !dut_set ? 1'b1 : model_q;
        miss  = ((state == RUN) || (state == DRAIN)) && (dut_q !== exp_q);
        err_n = (miss && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        fev_n = (miss && first_err_vec == 16'hFFFF) ? cnt[15:0] : first_err_vec;
        state_n      = state;
        cnt_n        = cnt;
        prev_pulse_n = prev_pulse;
        lfsr_load    = 1'b0;
        load_vec     = 1'b0;
        clr          = 1'b0;
        r_n          = 1'b0;
        s_n          = 1'b1;
        d_n          = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                r_n = (state == IDLE) || start;
                if (start) begin
                    state_n      = INIT;
                    cnt_n        = '0;
                    prev_pulse_n = 1'b0;
                    lfsr_load    = 1'b1;
                    clr          = 1'b1;
                end
            end
            INIT: begin
                state_n  = (NUM_VEC == 0) ? DRAIN : RUN;
                load_vec = (NUM_VEC != 0);
            end
            RUN: begin
                state_n  = (cnt == LAST) ? DRAIN : RUN;
                cnt_n    = cnt + CW'(1);
                load_vec = (cnt != LAST);
            end
            DRAIN: state_n = DONE;
            default: state_n = IDLE;
        endcase
        // outputs are registered, so the vector built here is on the pins during the next cycle
        if (load_vec) begin
            r_n          = pulse && (kind != PK_SET);
            s_n          = !(pulse && (kind == PK_SET || kind == PK_BOTH));
            d_n          = lfsr[6];
            prev_pulse_n = pulse;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            prev_pulse    <= 1'b0;
            model_q       <= 1'b0;
            dut_d         <= 1'b0;
            dut_reset     <= 1'b1;
            dut_set       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 16'h0000;
            first_err_vec <= 16'hFFFF;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            prev_pulse    <= prev_pulse_n;
            model_q       <= dut_reset ? 1'b0 : !dut_set ? 1'b1 : dut_d;
            dut_d         <= d_n;
            dut_reset     <= r_n;
            dut_set       <= s_n;
            busy          <= state_n inside {INIT, RUN, DRAIN};
            done          <= (state_n == DONE);
            pass          <= (state_n == DONE) && (err_n == 16'h0000);
            err_count     <= clr ? 16'h0000 : err_n;
            first_err_vec <= clr ? 16'hFFFF : fev_n;
        end

endmodule

// File: tb/tb_rsff_stim_chk.sv
// tb_rsff_stim_chk: directed bench for rsff_stim_chk driving behavioural RSFF cells (good and faulty)
module tb_rsff_stim_chk;

    localparam int N = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, start, busy, done, pass, dd, dr, ds;
    logic         dq  [N];
    logic [15:0]  err [N];
    logic [15:0]  fev [N];

    logic er [0:257];
    logic es [0:257];
    logic ed [0:257];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int   idx;
        int   cyc;
        logic pass;
        int   err;
        int   fev;
    } vec_t;

    vec_t tbl [N];

    // 0..2: good cell (256/0/1 vectors); 3: set-priority cell, mask 3; 4: q stuck 0, mask 0; 5: inverted q, 70000 vectors
    rsff_stim_chk u0 (.clk(clk), .reset(rst[0]), .start(start[0]), .dut_d(dd[0]), .dut_reset(dr[0]), .dut_set(ds[0]),
        .dut_q(dq[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err[0]), .first_err_vec(fev[0]));
    rsff_stim_chk #(.NUM_VEC(0)) u1 (.clk(clk), .reset(rst[1]), .start(start[1]), .dut_d(dd[1]), .dut_reset(dr[1]),
        .dut_set(ds[1]), .dut_q(dq[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err[1]),
        .first_err_vec(fev[1]));
    rsff_stim_chk #(.NUM_VEC(1)) u2 (.clk(clk), .reset(rst[2]), .start(start[2]), .dut_d(dd[2]), .dut_reset(dr[2]),
        .dut_set(ds[2]), .dut_q(dq[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err[2]),
        .first_err_vec(fev[2]));
    rsff_stim_chk #(.PULSE_MASK(4'h3)) u3 (.clk(clk), .reset(rst[3]), .start(start[3]), .dut_d(dd[3]),
        .dut_reset(dr[3]), .dut_set(ds[3]), .dut_q(dq[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
        .err_count(err[3]), .first_err_vec(fev[3]));
    rsff_stim_chk #(.PULSE_MASK(4'h0)) u4 (.clk(clk), .reset(rst[4]), .start(start[4]), .dut_d(dd[4]),
        .dut_reset(dr[4]), .dut_set(ds[4]), .dut_q(dq[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]),
        .err_count(err[4]), .first_err_vec(fev[4]));
    rsff_stim_chk #(.NUM_VEC(70000)) u5 (.clk(clk), .reset(rst[5]), .start(start[5]), .dut_d(dd[5]),
        .dut_reset(dr[5]), .dut_set(ds[5]), .dut_q(dq[5]), .busy(busy[5]), .done(done[5]), .pass(pass[5]),
        .err_count(err[5]), .first_err_vec(fev[5]));

    for (genvar g = 0; g < N; g++) begin : g_cell
        logic q;
        always @(posedge clk or posedge dr[g] or negedge ds[g])
            if (g == 3 && !ds[g]) q <= 1'b1;
            else if (dr[g]) q <= 1'b0;
            else if (!ds[g]) q <= 1'b1;
            else q <= dd[g];
        assign dq[g] = (g == 4) ? 1'b0 : (g == 5) ? ~q : q;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference run: kind 0 good cell, 1 set-priority cell, 2 q stuck at 0
    task automatic model(input logic [3:0] mask, input int nv, input int kind, input bit rec,
                         output int e, output int f);
        logic [15:0] v = 16'hACE1;
        logic pp = 1'b0, p, r, s, d, q, eq, mg, ms;
        logic pr = 1'b1, ps = 1'b1, pd = 1'b0;
        e = 0;
        f = 65535;
        if (rec) begin er[0] = 1'b1; es[0] = 1'b1; ed[0] = 1'b0; end
        for (int c = 0; c <= nv; c++) begin
            if (c < nv) begin
                p  = ((v[3:0] & mask) == 4'h0) && !pp;
                r  = p && (v[5:4] != 2'b01);
                s  = !(p && (v[5:4] == 2'b01 || v[5:4] == 2'b10));
                d  = v[6];
                pp = p;
                v  = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
            end else begin
                r = 1'b0; s = 1'b1; d = 1'b0;
            end
            if (rec) begin er[c+1] = r; es[c+1] = s; ed[c+1] = d; end
            mg = pr ? 1'b0 : !ps ? 1'b1 : pd;
            ms = !ps ? 1'b1 : pr ? 1'b0 : pd;
            eq = r ? 1'b0 : !s ? 1'b1 : mg;
            q  = (kind == 0) ? eq : (kind == 1) ? (!s ? 1'b1 : r ? 1'b0 : ms) : 1'b0;
            if (q != eq) begin
                if (e != 65535) e++;
                if (f == 65535) f = c;
            end
            pr = r; ps = s; pd = d;
        end
    endtask

    task automatic run(input int i, output int n);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        n = 1;
        while (!done[i] && n < 70100) begin
            @(negedge clk);
            n++;
        end
        n--;
    endtask

    task automatic pin_run(input bit poke);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int j = 0; j < 258; j++) begin
            if (j > 0) @(negedge clk);
            start[0] = poke && (j == 50);
            chk($sformatf("pins_cyc%0d", j), {dr[0], ds[0], dd[0]}, {er[j], es[j], ed[j]});
        end
        @(negedge clk);
        chk("pin_run_done", done[0], 1);
        chk("pin_run_pass", pass[0], 1);
        chk("pin_run_err", err[0], 0);
    endtask

    initial begin
        int n, e3, f3, e4, f4, eo, fo;
        rst   = '0;
        start = '0;
        model(4'hF, 256, 0, 1'b1, eo, fo);
        model(4'h3, 256, 1, 1'b0, e3, f3);
        model(4'h0, 256, 2, 1'b0, e4, f4);
        tbl[0] = '{0, 258, 1'b1, 0, 65535};
        tbl[1] = '{1, 2, 1'b1, 0, 65535};
        tbl[2] = '{2, 3, 1'b1, 0, 65535};
        tbl[3] = '{3, 258, e3 == 0, e3, f3};
        tbl[4] = '{4, 258, e4 == 0, e4, f4};
        tbl[5] = '{5, 70002, 1'b0, 65535, 0};
        #2 rst = '1;
        repeat (2) @(negedge clk);
        rst = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst%0d_busy", i), busy[i], 0);
            chk($sformatf("rst%0d_done", i), done[i], 0);
            chk($sformatf("rst%0d_pass", i), pass[i], 0);
            chk($sformatf("rst%0d_err", i), err[i], 0);
            chk($sformatf("rst%0d_fev", i), fev[i], 16'hFFFF);
            chk($sformatf("rst%0d_pins", i), {dr[i], ds[i], dd[i]}, 3'b110);
        end
        chk("model_good_clean", eo, 0);
        chk("model_setprio_sees_both", e3 > 0, 1);
        for (int k = 0; k < N; k++) begin
            run(tbl[k].idx, n);
            chk($sformatf("inst%0d_cycles", k), n, tbl[k].cyc);
            chk($sformatf("inst%0d_done", k), done[tbl[k].idx], 1);
            chk($sformatf("inst%0d_busy", k), busy[tbl[k].idx], 0);
            chk($sformatf("inst%0d_pass", k), pass[tbl[k].idx], tbl[k].pass);
            chk($sformatf("inst%0d_err", k), err[tbl[k].idx], tbl[k].err);
            chk($sformatf("inst%0d_fev", k), fev[tbl[k].idx], tbl[k].fev);
        end
        pin_run(1'b1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (101) @(negedge clk);
        rst[0] = 1'b1;
        #1;
        chk("midrst_dut_reset", dr[0], 1);
        chk("midrst_busy", busy[0], 0);
        chk("midrst_err", err[0], 0);
        chk("midrst_fev", fev[0], 16'hFFFF);
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        pin_run(1'b0);
        run(3, n);
        chk("restart3_cycles", n, 258);
        chk("restart3_err", err[3], e3);
        chk("restart3_fev", fev[3], f3);
        chk("restart3_pass", pass[3], 0);
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        repeat (150) @(negedge clk);
        rst[3] = 1'b1;
        #1;
        chk("midrst3_dut_reset", dr[3], 1);
        chk("midrst3_busy", busy[3], 0);
        chk("midrst3_err", err[3], 0);
        chk("midrst3_fev", fev[3], 16'hFFFF);
        @(negedge clk);
        rst[3] = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
